// File: rtl/serial_word_transmitter.sv
// LSB-first parallel-to-serial word transmitter with a frame strobe on bit 0 and a done pulse.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit after the last data bit.
module serial_word_transmitter #(
  parameter int WORD_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic                  serial_out,
  output logic                  frame,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLKS_PER_BIT - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  div_wrap;

  assign div_wrap = (div_q == LAST_DIV);
  assign done     = done_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_d      = div_q;
    done_d     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    load_ready = 1'b0;
    busy       = 1'b0;
    serial_out = 1'b0;
    frame      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          div_d     = '0;
          state_d   = ST_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
          // Parity is fixed at capture time so later data_in activity cannot disturb it.
          parity_d  = ^data_in;
`endif
        end
      end

      ST_SHIFT: begin
        busy       = 1'b1;
        serial_out = shift_q[0];
        frame      = (bit_cnt_q == '0);
        div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        busy       = 1'b1;
        serial_out = parity_q;
        div_d      = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      done_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      done_q    <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Scoreboard bench for serial_word_transmitter: two instances (CLKS_PER_BIT 1 and 4),
// accepted words queued per instance and checked bit-by-bit by a negedge monitor.
`timescale 1ns/1ps
module tb_serial_word_transmitter;

  localparam int W    = 32;
  localparam int CPB0 = 1;
  localparam int CPB1 = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         lv  [2];
  logic [W-1:0] din [2];
  logic         rdy [2];
  logic         so  [2];
  logic         frm [2];
  logic         bsy [2];
  logic         dn  [2];

  always #5 clk = ~clk;

  serial_word_transmitter #(.WORD_WIDTH(W), .CLKS_PER_BIT(CPB0)) u_dut0 (
    .clk(clk), .reset(reset), .load_valid(lv[0]), .load_ready(rdy[0]), .data_in(din[0]),
    .serial_out(so[0]), .frame(frm[0]), .busy(bsy[0]), .done(dn[0])
  );

  serial_word_transmitter #(.WORD_WIDTH(W), .CLKS_PER_BIT(CPB1)) u_dut1 (
    .clk(clk), .reset(reset), .load_valid(lv[1]), .load_ready(rdy[1]), .data_in(din[1]),
    .serial_out(so[1]), .frame(frm[1]), .busy(bsy[1]), .done(dn[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input int d, input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, got, want);
    end
  endtask

  function automatic int cpb(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  // Reference: even-parity bit is 1 when the word has an odd number of ones.
  function automatic logic ref_parity(input logic [W-1:0] w);
    return ($countones(w) % 2) == 1;
  endfunction

  // ---------------- scoreboard producer: record accepted words ----------------
  logic         prev_rst = 1'b0;
  logic         acc [2] = '{1'b0, 1'b0};
  logic [W-1:0] exp_q0 [$];
  logic [W-1:0] exp_q1 [$];

  always @(posedge clk) begin
    prev_rst <= reset;
    for (int d = 0; d < 2; d++) begin
      acc[d] <= lv[d] && rdy[d] && !reset;
      if (lv[d] && rdy[d] && !reset) begin
        if (d == 0) exp_q0.push_back(din[d]);
        else        exp_q1.push_back(din[d]);
      end
    end
  end

  // ---------------- monitor: pops expected word and checks every cycle ----------------
  bit           mon_en = 1'b0;
  bit           act   [2] = '{1'b0, 1'b0};
  bit           wdone [2] = '{1'b0, 1'b0};
  int           pos   [2] = '{0, 0};
  logic [W-1:0] cur     [2];
  logic [W-1:0] rebuilt [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int   c;
      int   nbits;
      int   len;
      logic eb;
      c     = cpb(d);
      nbits = W * c;
      len   = nbits + (PAR ? c : 0);
      if (prev_rst) begin
        mon_en   = 1'b1;
        act[d]   = 1'b0;
        wdone[d] = 1'b0;
        check(d, "reset_ready",  32'(rdy[d]), 32'd1);
        check(d, "reset_busy",   32'(bsy[d]), 32'd0);
        check(d, "reset_serial", 32'(so[d]),  32'd0);
        check(d, "reset_frame",  32'(frm[d]), 32'd0);
        check(d, "reset_done",   32'(dn[d]),  32'd0);
      end else if (mon_en) begin
        if (acc[d]) begin
          check(d, "accept_while_busy", 32'(act[d] || wdone[d]), 32'd0);
          if (d == 0 && exp_q0.size() > 0) cur[d] = exp_q0.pop_front();
          if (d == 1 && exp_q1.size() > 0) cur[d] = exp_q1.pop_front();
          act[d]     = 1'b1;
          wdone[d]   = 1'b0;
          pos[d]     = 0;
          rebuilt[d] = '0;
        end
        if (act[d]) begin
          eb = (pos[d] < nbits) ? cur[d][pos[d] / c] : ref_parity(cur[d]);
          check(d, "serial_bit",  32'(so[d]),  32'(eb));
          check(d, "frame",       32'(frm[d]), 32'(pos[d] < c));
          check(d, "busy_word",   32'(bsy[d]), 32'd1);
          check(d, "ready_word",  32'(rdy[d]), 32'd0);
          check(d, "done_early",  32'(dn[d]),  32'd0);
          if (pos[d] < nbits && (pos[d] % c) == 0) rebuilt[d][pos[d] / c] = so[d];
          pos[d]++;
          if (pos[d] == len) begin
            act[d]   = 1'b0;
            wdone[d] = 1'b1;
          end
        end else if (wdone[d]) begin
          check(d, "done_pulse",   32'(dn[d]),  32'd1);
          check(d, "done_ready",   32'(rdy[d]), 32'd1);
          check(d, "done_busy",    32'(bsy[d]), 32'd0);
          check(d, "done_frame",   32'(frm[d]), 32'd0);
          check(d, "done_serial",  32'(so[d]),  32'd0);
          check(d, "word_rebuilt", rebuilt[d],  cur[d]);
          wdone[d] = 1'b0;
        end else begin
          check(d, "idle_done",   32'(dn[d]),  32'd0);
          check(d, "idle_busy",   32'(bsy[d]), 32'd0);
          check(d, "idle_ready",  32'(rdy[d]), 32'd1);
          check(d, "idle_frame",  32'(frm[d]), 32'd0);
          check(d, "idle_serial", 32'(so[d]),  32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int d, input logic [W-1:0] w, output logic done_at_accept);
    int n;
    lv[d]  = 1'b1;
    din[d] = w;
    done_at_accept = 1'b0;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (rdy[d]) break;
    end
    check(d, "accept_timeout", 32'(n < 1000), 32'd1);
    done_at_accept = dn[d];
    @(posedge clk);
    #1;
    lv[d]  = 1'b0;
    din[d] = $urandom;
  endtask

  task automatic wait_idle(input int d);
    int n;
    for (n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (rdy[d]) break;
    end
    check(d, "idle_timeout", 32'(n < 1000), 32'd1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic dflag;
    for (int d = 0; d < 2; d++) begin
      lv[d]  = 1'b0;
      din[d] = '0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single set bit at one clock per bit, then the alternating pattern at four clocks per bit.
    send(0, 32'h0000_0001, dflag);
    wait_idle(0);
    send(1, 32'hA5A5_A5A5, dflag);
    wait_idle(1);

    // Word held pending while busy is accepted exactly on the done cycle.
    for (int d = 0; d < 2; d++) begin
      send(d, 32'h1234_5678, dflag);
      send(d, 32'hFFFF_FFFF, dflag);
      check(d, "accept_on_done", 32'(dflag), 32'd1);
      wait_idle(d);
    end

    // Reset while bit 10 of an all-ones word is on the line, then a clean word.
    send(0, 32'hFFFF_FFFF, dflag);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(0, 32'h1234_5678, dflag);
    wait_idle(0);

    // Odd and even population words exercise both parity values.
    for (int d = 0; d < 2; d++) begin
      send(d, 32'h0000_0007, dflag);
      wait_idle(d);
      send(d, 32'h0000_0003, dflag);
      wait_idle(d);
    end

    // Random words with a mix of idle gaps and back-to-back loads.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        send(d, $urandom, dflag);
        if ($urandom_range(0, 2) != 0) begin
          wait_idle(d);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      wait_idle(d);
    end

    repeat (3) @(negedge clk);
    check(0, "sb_empty", 32'(exp_q0.size()), 32'd0);
    check(1, "sb_empty", 32'(exp_q1.size()), 32'd0);
    check(0, "mon_idle", 32'(act[0] || wdone[0]), 32'd0);
    check(1, "mon_idle", 32'(act[1] || wdone[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
